// File: rtl/mux4_scan_pkg.sv
// Shared types and helpers for the 4:1 mux scan serializer.
package mux4_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  // order 0 walks channels 0->3, order 1 walks 3->0
  function automatic logic [SEL_W-1:0] chan_of(input logic [SEL_W-1:0] beat,
                                               input logic             order);
    return order ? (SEL_W'(NUM_CH - 1) - beat) : beat;
  endfunction

endpackage

// File: rtl/mux4_scan_serializer.sv
// Serializes 4-bit words through an external combinational 4:1 mux, one channel
// per beat, and flags any beat where the mux output disagrees with the selected bit.
module mux4_scan_serializer
  import mux4_scan_pkg::*;
#(
  parameter bit SCAN_ORDER = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] in_data,
  output logic [NUM_CH-1:0] mux_d,
  output logic [SEL_W-1:0]  mux_s,
  input  logic              mux_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last,
  output logic              err,
  output logic [CNT_W-1:0]  word_cnt
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  beat_q, beat_d;
  logic [NUM_CH-1:0] mux_d_q, mux_d_d;
  logic [SEL_W-1:0]  mux_s_q, mux_s_d;
  logic [NUM_CH-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              in_ready_q;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic beat_hs, last_hs, accept, direct;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      mux_d_q    <= '0;
      mux_s_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      mux_d_q    <= mux_d_d;
      mux_s_q    <= mux_s_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      in_ready_q <= !hold_vld_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    mux_d_d    = mux_d_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    cnt_d      = cnt_q;

    beat_hs = (state_q == SCAN) && out_ready;
    last_hs = beat_hs && (beat_q == SEL_W'(NUM_CH - 1));
    accept  = in_valid && in_ready_q;
    // The active slot frees up this edge when idle or finishing its last beat;
    // a word waiting in hold always has priority over the incoming one.
    direct  = accept && !hold_vld_q && ((state_q == IDLE) || last_hs);

    if (beat_hs) beat_d = beat_q + SEL_W'(1);

    if (last_hs) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (hold_vld_q) begin
        mux_d_d    = hold_q;
        hold_vld_d = 1'b0;
      end else if (!direct) begin
        state_d = IDLE;
      end
    end

    if (direct) begin
      mux_d_d = in_data;
      beat_d  = '0;
      state_d = SCAN;
    end else if (accept) begin
      hold_d     = in_data;
      hold_vld_d = 1'b1;
    end

    mux_s_d = chan_of(beat_d, SCAN_ORDER);
    err_d   = err_q ||
              ((state_q == SCAN) && (mux_y != mux_d_q[chan_of(beat_q, SCAN_ORDER)]));
  end

  always_comb begin
    out_valid = (state_q == SCAN);
    out_last  = out_valid && (beat_q == SEL_W'(NUM_CH - 1));
    out_bit   = mux_y;
    in_ready  = in_ready_q;
    mux_d     = mux_d_q;
    mux_s     = mux_s_q;
    err       = err_q;
    word_cnt  = cnt_q;
  end

endmodule

// File: tb/tb_mux4_scan_serializer.sv
// Scoreboard bench: unit 0 (SCAN_ORDER=0, CNT_W=16) with an optional stuck-at-0 mux,
// unit 1 (SCAN_ORDER=1, CNT_W=2) with a stalling downstream.
module tb_mux4_scan_serializer;

  typedef struct packed {
    logic       b;
    logic       last;
    logic [1:0] s;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n, in_valid, in_ready, out_valid, out_ready, out_bit, out_last, err, mux_y;
  logic [1:0][3:0] in_data, mux_d;
  logic [1:0][1:0] mux_s;
  logic [15:0]     wc_a;
  logic [1:0]      wc_b;
  logic            fault;

  assign mux_y[0] = fault ? 1'b0 : mux_d[0][mux_s[0]];
  assign mux_y[1] = mux_d[1][mux_s[1]];

  mux4_scan_serializer #(.SCAN_ORDER(1'b0), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .mux_d(mux_d[0]), .mux_s(mux_s[0]), .mux_y(mux_y[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_bit(out_bit[0]),
    .out_last(out_last[0]), .err(err[0]), .word_cnt(wc_a));

  mux4_scan_serializer #(.SCAN_ORDER(1'b1), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .mux_d(mux_d[1]), .mux_s(mux_s[1]), .mux_y(mux_y[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_bit(out_bit[1]),
    .out_last(out_last[1]), .err(err[1]), .word_cnt(wc_b));

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   hs_cnt[2]   = '{0, 0};
  int   last_cyc[2] = '{0, 0};
  int   last_cnt[2] = '{0, 0};
  int   acc_cyc = 0;
  logic [1:0]      stall_prev = 2'b00;
  logic [1:0][7:0] snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int q_size(input int i);
    return (i == 1) ? q1.size() : q0.size();
  endfunction

  function automatic exp_t q_pop(input int i);
    if (i == 1) return q1.pop_front();
    return q0.pop_front();
  endfunction

  function automatic logic [7:0] cur_snap(input int i);
    return {mux_d[i], mux_s[i], out_valid[i], out_last[i]};
  endfunction

  // Monitor: pops one expected beat per output handshake; checks stall stability.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (stall_prev[i])
        check($sformatf("stall_stable_u%0d", i), {24'd0, cur_snap(i)}, {24'd0, snap[i]});
      if (rst_n[i] && out_valid[i] && out_ready[i]) begin
        if (q_size(i) == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat_u%0d: got bit %0d with nothing expected", i, out_bit[i]);
        end else begin
          e = q_pop(i);
          check($sformatf("beat_u%0d{bit,last,sel}", i),
                {28'd0, out_bit[i], out_last[i], mux_s[i]}, {28'd0, e});
        end
        hs_cnt[i]++;
        last_cyc[i] = cyc;
        if (out_last[i]) last_cnt[i]++;
      end
      stall_prev[i] = rst_n[i] & out_valid[i] & ~out_ready[i];
      snap[i]       = cur_snap(i);
    end
  end

  // seq lists the four expected output bits in emission order, first bit at seq[3].
  task automatic send(input int i, input logic [3:0] data, input logic [3:0] seq, input bit keep);
    logic rdy;
    bit   done;
    exp_t e;
    done        = 1'b0;
    in_valid[i] = 1'b1;
    in_data[i]  = data;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      rdy = in_ready[i];
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    if (!keep) in_valid[i] = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout_u%0d: word %h not accepted in 50 cycles", i, data);
    end else begin
      acc_cyc = cyc;
      for (int k = 0; k < 4; k++) begin
        e.b    = seq[3-k];
        e.last = (k == 3);
        e.s    = (i == 1) ? 2'(3 - k) : 2'(k);
        if (i == 1) q1.push_back(e);
        else q0.push_back(e);
      end
    end
  endtask

  task automatic drain(input int i);
    int n;
    n = 0;
    while (q_size(i) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q_size(i) != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout_u%0d: %0d beats outstanding, need 0", i, q_size(i));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input int i);
    check($sformatf("rst_in_ready_u%0d", i), {31'd0, in_ready[i]}, 32'd0);
    check($sformatf("rst_out_valid_u%0d", i), {31'd0, out_valid[i]}, 32'd0);
    check($sformatf("rst_out_last_u%0d", i), {31'd0, out_last[i]}, 32'd0);
    check($sformatf("rst_mux_d_u%0d", i), {28'd0, mux_d[i]}, 32'd0);
    check($sformatf("rst_mux_s_u%0d", i), {30'd0, mux_s[i]}, 32'd0);
    check($sformatf("rst_err_u%0d", i), {31'd0, err[i]}, 32'd0);
  endtask

  initial begin
    int c0, h0, lc0, idx;
    logic [3:0] pat;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, h0, lc0, idx;
    logic [3:0] pat;
    pat       = 4'b1001;
    rst_n     = 2'b00;
    in_valid  = 2'b00;
    in_data   = '0;
    out_ready = 2'b11;
    fault     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals(0);
    check_reset_vals(1);
    check("rst_wc_a", {16'd0, wc_a}, 32'd0);
    check("rst_wc_b", {30'd0, wc_b}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 2'b11;
    @(posedge clk);
    #1;
    check("in_ready_after_rst_u0", {31'd0, in_ready[0]}, 32'd1);
    check("in_ready_after_rst_u1", {31'd0, in_ready[1]}, 32'd1);

    // single word 1010 -> 0,1,0,1
    h0 = hs_cnt[0];
    send(0, 4'b1010, 4'b0101, 1'b0);
    c0 = acc_cyc;
    drain(0);
    check("t1_beats", hs_cnt[0] - h0, 32'd4);
    check("t1_contig", last_cyc[0] - c0, 32'd3);
    check("t1_wc", {16'd0, wc_a}, 32'd1);
    check("t1_idle", {31'd0, out_valid[0]}, 32'd0);
    check("t1_err", {31'd0, err[0]}, 32'd0);

    // C,3,F back to back
    h0 = hs_cnt[0];
    send(0, 4'hC, 4'b0011, 1'b1);
    c0 = acc_cyc;
    send(0, 4'h3, 4'b1100, 1'b1);
    send(0, 4'hF, 4'b1111, 1'b0);
    drain(0);
    check("t2_beats", hs_cnt[0] - h0, 32'd12);
    check("t2_contig", last_cyc[0] - c0, 32'd11);
    check("t2_wc", {16'd0, wc_a}, 32'd4);
    check("t2_err", {31'd0, err[0]}, 32'd0);

    // next word accepted during the last beat with hold empty: direct load
    h0 = hs_cnt[0];
    send(0, 4'h9, 4'b1001, 1'b0);
    c0 = acc_cyc;
    repeat (3) @(posedge clk);
    #1;
    send(0, 4'h4, 4'b0010, 1'b0);
    check("t3_direct_edge", acc_cyc - c0, 32'd4);
    drain(0);
    check("t3_beats", hs_cnt[0] - h0, 32'd8);
    check("t3_contig", last_cyc[0] - c0, 32'd7);
    check("t3_wc", {16'd0, wc_a}, 32'd6);

    // stuck-at-0 mux
    fault = 1'b1;
    send(0, 4'hF, 4'b0000, 1'b0);
    @(negedge clk);
    check("fault_err_first_beat", {31'd0, err[0]}, 32'd0);
    @(negedge clk);
    check("fault_err_next_cycle", {31'd0, err[0]}, 32'd1);
    drain(0);
    fault = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("fault_err_sticky", {31'd0, err[0]}, 32'd1);
    check("fault_wc", {16'd0, wc_a}, 32'd7);

    // reset after the 2nd beat of A with 5 waiting in hold
    lc0 = last_cnt[0];
    send(0, 4'hA, 4'b0101, 1'b0);
    send(0, 4'h5, 4'b1010, 1'b0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    @(negedge clk);
    check_reset_vals(0);
    check("midrst_wc", {16'd0, wc_a}, 32'd0);
    check("midrst_no_last", last_cnt[0] - lc0, 32'd0);
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    send(0, 4'h6, 4'b0110, 1'b0);
    drain(0);
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_wc", {16'd0, wc_a}, 32'd1);
    check("post_rst_last", last_cnt[0] - lc0, 32'd1);
    check("post_rst_err", {31'd0, err[0]}, 32'd0);

    // unit 1: reverse order, out_ready pattern 1,0,0,1
    send(1, 4'b0001, 4'b0001, 1'b0);
    idx = 0;
    for (int n = 0; n < 40 && q1.size() != 0; n++) begin
      out_ready[1] = pat[3 - (idx % 4)];
      idx++;
      @(posedge clk);
      #1;
    end
    out_ready[1] = 1'b1;
    check("rev_drained", q1.size(), 32'd0);
    check("rev_wc", {30'd0, wc_b}, 32'd1);
    check("rev_idle", {31'd0, out_valid[1]}, 32'd0);

    // four more words: 5 total, 2-bit counter wraps to 1
    send(1, 4'h5, 4'b0101, 1'b1);
    send(1, 4'hA, 4'b1010, 1'b1);
    send(1, 4'h8, 4'b1000, 1'b1);
    send(1, 4'h2, 4'b0010, 1'b0);
    drain(1);
    check("wrap_wc", {30'd0, wc_b}, 32'd1);
    check("wrap_err", {31'd0, err[1]}, 32'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
